// File: rtl/pack_pkg.sv
// Shared types for the pack_load_mc sample packer: FSM state encoding and byte selection.
package pack_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_LATCH,
        S_SHIFT,
        S_CHECK,
        S_DONE
    } state_t;

    // Byte idx (0 = least significant) of a 32-bit channel word.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/pack_ser.sv
// Load-and-shift serialiser: captures CH*BPS bytes from a buffer word and emits them
// ch0 first, most significant kept byte first, one per valid/ready handshake.
module pack_ser
    import pack_pkg::*;
#(
    parameter int CH  = 3,
    parameter int BPS = 3
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CH*32-1:0] q_all_i,
    input  logic             en_i,
    input  logic             rdy_i,
    output logic [7:0]       data_o,
    output logic             vld_o,
    output logic             last_o
);
    localparam int NB = CH * BPS;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [NB*8-1:0] sr_q, sr_d, pack;
    logic [IW-1:0]   idx_q, idx_d;
    logic            hs;

    always_comb begin
        pack = '0;
        for (int k = 0; k < CH; k++) begin
            for (int b = 0; b < BPS; b++) begin
                pack[8*(NB-1-(k*BPS+BPS-1-b)) +: 8] = word_byte(q_all_i[32*k +: 32], 2'(b));
            end
        end
    end

    assign hs     = en_i & rdy_i;
    assign last_o = hs && (idx_q == IW'(NB-1));
    assign vld_o  = en_i;
    assign data_o = sr_q[NB*8-1 -: 8];

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (load_i) begin
            sr_d  = pack;
            idx_d = '0;
        end else if (hs) begin
            sr_d  = sr_q << 8;
            idx_d = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/pack_load_mc.sv
// Multi-channel sample packer: reads sample sets from a ring buffer and streams
// the low BPS bytes of each channel word downstream, then pulses done_load.
module pack_load_mc
    import pack_pkg::*;
#(
    parameter int CH  = 3,
    parameter int BPS = 3,
    parameter int AW  = 12,
    parameter int CW  = 8
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             fire_load,
    input  logic             abort_load,
    output logic             done_load,
    output logic             busy,
    output logic [7:0]       load_data,
    output logic             load_vld,
    input  logic             load_rdy,
    input  logic [AW-1:0]    buf_waddr,
    output logic [AW-1:0]    buf_raddr,
    input  logic [CH*32-1:0] q_all,
    input  logic [CW-1:0]    cfg_sample
);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          ser_load, ser_last;

    pack_ser #(.CH(CH), .BPS(BPS)) u_ser (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .load_i  (ser_load),
        .q_all_i (q_all),
        .en_i    (state_q == S_SHIFT),
        .rdy_i   (load_rdy),
        .data_o  (load_data),
        .vld_o   (load_vld),
        .last_o  (ser_last)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        raddr_d  = raddr_q;
        ser_load = 1'b0;
        case (state_q)
            S_IDLE: if (fire_load) begin
                cnt_d   = cfg_sample;
                state_d = (cfg_sample == '0) ? S_DONE : S_WAIT;
            end
            S_WAIT:  if (buf_waddr != raddr_q) state_d = S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                ser_load = 1'b1;
                raddr_d  = raddr_q + AW'(1);
                state_d  = S_SHIFT;
            end
            S_SHIFT: if (ser_last) begin
                cnt_d   = cnt_q - CW'(1);
                state_d = S_CHECK;
            end
            S_CHECK: state_d = (cnt_q == '0) ? S_DONE : S_WAIT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort keeps the pointer: a set already latched is dropped, not re-read.
        if (abort_load) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            ser_load = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
        end
    end

    assign done_load = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign buf_raddr = raddr_q;

endmodule

// File: tb/tb_pack_load_mc.sv
// Scoreboard bench for pack_load_mc: stimulus pushes expected bytes, a negedge monitor checks them.
module tb_pack_load_mc;
    localparam int CH = 3, BPS = 3, AW = 12, CW = 8;

    logic             clk_sys = 1'b0;
    logic             rst_n = 1'b0;
    logic             fire_load = 1'b0, abort_load = 1'b0, load_rdy = 1'b1;
    logic [AW-1:0]    buf_waddr = '0;
    logic [CW-1:0]    cfg_sample = '0;
    logic [CH*32-1:0] q_all = '0;
    logic             done_load, busy, load_vld;
    logic [7:0]       load_data;
    logic [AW-1:0]    buf_raddr;

    pack_load_mc #(.CH(CH), .BPS(BPS), .AW(AW), .CW(CW)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .fire_load(fire_load), .abort_load(abort_load),
        .done_load(done_load), .busy(busy), .load_data(load_data), .load_vld(load_vld),
        .load_rdy(load_rdy), .buf_waddr(buf_waddr), .buf_raddr(buf_raddr), .q_all(q_all),
        .cfg_sample(cfg_sample)
    );

    always #5 clk_sys = ~clk_sys;

    logic [CH*32-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk_sys) q_all <= mem[buf_raddr];

    logic [7:0] exp_q[$];
    int nvec = 0, nerr = 0, hs_cnt = 0, done_cnt = 0, done_exp = 0, rdy_mode = 0;
    logic hold = 1'b0;
    logic [7:0] held = '0;

    logic [7:0] t1 [18] = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Ready driver: 0 = high, 1 = toggle every cycle, 2 = low.
    initial forever begin
        @(posedge clk_sys) #2;
        case (rdy_mode)
            0: load_rdy = 1'b1;
            1: load_rdy = ~load_rdy;
            default: load_rdy = 1'b0;
        endcase
    end

    always @(negedge clk_sys) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold && load_vld) chk("hold_stable", load_data, held);
            if (load_vld && load_rdy) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL unexpected_byte: got %0h expected none at %0t", load_data, $time);
                end else begin
                    chk("byte", load_data, exp_q.pop_front());
                end
            end
            hold = load_vld && !load_rdy;
            held = load_data;
            if (done_load) done_cnt++;
        end
    end

    task automatic push_set(input logic [AW-1:0] a);
        for (int k = 0; k < CH; k++)
            for (int b = BPS-1; b >= 0; b--)
                exp_q.push_back(mem[a][32*k + 8*b +: 8]);
    endtask

    task automatic fire(input int n);
        @(posedge clk_sys) #1;
        cfg_sample = CW'(n);
        fire_load  = 1'b1;
        @(posedge clk_sys) #1;
        fire_load  = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string nm);
        for (int i = 0; i < lim && done_cnt < done_exp; i++) @(posedge clk_sys);
        chk(nm, done_cnt, done_exp);
        repeat (3) @(posedge clk_sys);
        chk({nm, "_once"}, done_cnt, done_exp);
        chk({nm, "_drain"}, exp_q.size(), 0);
        chk({nm, "_idle"}, busy, 0);
    endtask

    task automatic wait_hs(input int target, input string nm);
        int i;
        for (i = 0; i < 200 && hs_cnt < target; i++) @(posedge clk_sys);
        chk(nm, (hs_cnt >= target), 1);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rem, n, base;
        for (int a = 0; a < (1<<AW); a++) mem[a] = {$urandom, $urandom, $urandom};
        mem[0] = {32'h00445566, 32'h00112233, 32'h00AABBCC};
        mem[1] = {32'h00070809, 32'h00040506, 32'h00010203};
        mem[2] = mem[0];
        mem[3] = mem[1];

        #3;
        chk("rst_vld", load_vld, 0);
        chk("rst_done", done_load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_raddr", buf_raddr, 0);
        chk("rst_data", load_data, 0);
        #20 rst_n = 1'b1;

        // Two sets, ready high
        buf_waddr = 12'd2;
        foreach (t1[i]) exp_q.push_back(t1[i]);
        done_exp++;
        fire(2);
        wait_done(100, "t1_done");
        chk("t1_raddr", buf_raddr, 2);

        // Same data, ready toggling
        buf_waddr = 12'd4;
        rdy_mode  = 1;
        foreach (t1[i]) exp_q.push_back(t1[i]);
        done_exp++;
        fire(2);
        wait_done(200, "t2_done");
        chk("t2_raddr", buf_raddr, 4);
        rdy_mode = 0;

        // Zero-length burst
        fire(0);
        done_exp++;
        @(negedge clk_sys);
        chk("t3_done_now", done_load, 1);
        chk("t3_no_vld", load_vld, 0);
        wait_done(10, "t3_done");
        chk("t3_raddr", buf_raddr, 4);

        // Empty buffer stall, then one set at a time
        fire(2);
        repeat (10) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("t4_busy", busy, 1);
        chk("t4_no_vld", load_vld, 0);
        push_set(12'd4);
        buf_waddr = 12'd5;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk_sys);
        repeat (8) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("t4_set1_drain", exp_q.size(), 0);
        chk("t4_wait_busy", busy, 1);
        chk("t4_wait_nodone", done_cnt, done_exp);
        chk("t4_wait_raddr", buf_raddr, 5);
        push_set(12'd5);
        done_exp++;
        buf_waddr = 12'd6;
        wait_done(100, "t4_done");
        chk("t4_raddr", buf_raddr, 6);

        // Advance pointer to 0xFFF
        buf_waddr = 12'hFFF;
        rem = 12'hFFF - 6;
        while (rem > 0) begin
            n = (rem > 255) ? 255 : rem;
            for (int s = 0; s < n; s++) push_set(AW'(12'hFFF - rem + s));
            done_exp++;
            fire(n);
            wait_done(n*20 + 50, "ff_done");
            rem -= n;
        end
        chk("ff_raddr", buf_raddr, 12'hFFF);

        // Wrap-around
        buf_waddr = 12'h001;
        push_set(12'hFFF);
        push_set(12'h000);
        done_exp++;
        fire(2);
        wait_done(100, "t5_done");
        chk("t5_raddr", buf_raddr, 1);

        // Abort during the 4th byte of the first set
        buf_waddr = 12'd3;
        base = hs_cnt;
        for (int b = 0; b < 3; b++) exp_q.push_back(mem[1][8*(BPS-1-b) +: 8]);
        fire(2);
        wait_hs(base + 3, "t6_three_bytes");
        #1;
        abort_load = 1'b1;
        rdy_mode   = 2;
        @(posedge clk_sys) #1;
        abort_load = 1'b0;
        @(negedge clk_sys);
        chk("t6_vld_low", load_vld, 0);
        chk("t6_busy_low", busy, 0);
        chk("t6_raddr", buf_raddr, 2);
        rdy_mode = 0;
        repeat (4) @(posedge clk_sys);
        chk("t6_no_done", done_cnt, done_exp);
        chk("t6_drain", exp_q.size(), 0);
        push_set(12'd2);
        done_exp++;
        fire(1);
        wait_done(100, "t6_resume");
        chk("t6_resume_raddr", buf_raddr, 3);

        // Reset mid-burst
        buf_waddr = 12'd4;
        base = hs_cnt;
        push_set(12'd3);
        fire(1);
        wait_hs(base + 2, "t7_two_bytes");
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk_sys);
        chk("t7_raddr", buf_raddr, 0);
        chk("t7_vld", load_vld, 0);
        chk("t7_busy", busy, 0);
        chk("t7_done", done_load, 0);
        chk("t7_data", load_data, 0);
        #20 rst_n = 1'b1;
        repeat (3) @(posedge clk_sys);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
